// File: rtl/mips_pkg.sv
// Shared types for the MIPS core: machine word, reset vector and the
// fetch entry carried from the fetch unit to the datapath.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, clear and occupancy count.
// Clear dominates push and pop; DEPTH must be a power of two.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: credit-limited sequential word fetches, in-order response
// buffering with PCs, and redirect handling that discards stale responses.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter word_t       RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    word_t        fetch_pc;
    word_t        resp_pc;
    word_t        redirect_word;
    cnt_t         outstanding;
    cnt_t         drop_cnt;
    cnt_t         count;
    cnt_t         out_next;
    cnt_t         drop_next;
    logic [CW:0]  used;
    logic         accept;
    logic         drop_resp;
    logic         push;
    logic         pop;
    fetch_entry_t head;

    assign used          = {1'b0, count} + {1'b0, outstanding};
    assign imem_req      = rst_n && !redirect_valid && (used < (CW + 1)'(DEPTH));
    assign imem_addr     = fetch_pc;
    assign accept        = imem_req && imem_ready;
    assign redirect_word = redirect_pc & ~32'h3;
    assign instr_valid   = (count != '0);
    assign pop           = instr_valid && instr_ready;
    assign instr         = instr_valid ? head.instr : '0;
    assign instr_pc      = instr_valid ? head.pc : '0;

    // On redirect every request still in flight is stale, already-pending
    // drops included, so the discard count becomes the post-cycle outstanding.
    always_comb begin
        drop_resp = imem_rvalid && (drop_cnt != '0);
        push      = imem_rvalid && !drop_resp && !redirect_valid;
        out_next  = outstanding + cnt_t'(accept) - cnt_t'(imem_rvalid);
        drop_next = drop_resp ? drop_cnt - cnt_t'(1) : drop_cnt;
        if (redirect_valid) begin
            drop_next = out_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_word;
                resp_pc  <= redirect_word;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data('{pc: resp_pc, instr: imem_rdata}),
        .pop      (pop),
        .clear    (redirect_valid),
        .head     (head),
        .count    (count)
    );

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order variable-latency memory model plus an
// expected-PC stream model, directed scenarios then randomized traffic.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam word_t       RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        word_t       addr;
        int unsigned due;
        int unsigned ep;
    } req_t;

    req_t        mq[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc;
    int unsigned epoch;
    int unsigned lat_min;
    int unsigned lat_max;
    int unsigned n_accept;
    int unsigned phase_pops;
    int unsigned phase_first_cyc;
    int          live;
    word_t       exp_pc;
    word_t       exp_fetch;
    word_t       phase_first_pc;
    logic        last_valid;
    logic        last_pop;

    function automatic word_t mem_word(input word_t a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic phase_start();
        phase_pops      = 0;
        phase_first_cyc = 0;
        phase_first_pc  = '0;
        n_accept        = 0;
    endtask

    task automatic do_reset(input int unsigned lmin, input int unsigned lmax);
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, RPC);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mq.delete();
        cyc       = 1;
        epoch     = 0;
        live      = 0;
        exp_pc    = RPC;
        exp_fetch = RPC;
        lat_min   = lmin;
        lat_max   = lmax;
        phase_start();
    endtask

    // One clock: drive inputs at negedge, observe just after, update the model.
    task automatic tick(input logic mrdy, input logic crdy, input logic redir, input word_t rpc);
        logic        acc;
        logic        pop;
        logic        rv;
        int unsigned due;
        int unsigned stale;
        @(negedge clk);
        imem_ready     = mrdy;
        instr_ready    = crdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rv             = (mq.size() != 0) && (mq[0].due <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(mq[0].addr) : $urandom();
        #1;
        acc = imem_req && imem_ready;
        pop = instr_valid && instr_ready;
        if (!instr_valid) begin
            check_eq("idle_instr", instr, 32'd0);
            check_eq("idle_pc", instr_pc, 32'd0);
        end
        if (redir) check_eq("req_in_redirect", 32'(imem_req), 32'd0);
        if (rv) void'(mq.pop_front());
        if (acc) begin
            check_eq("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mq.size() != 0 && mq[$].due >= due) due = mq[$].due + 1;
            mq.push_back('{addr: imem_addr, due: due, ep: epoch});
            live++;
            n_accept++;
        end
        if (pop) begin
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            live--;
            phase_pops++;
            if (phase_pops == 1) begin
                phase_first_pc  = instr_pc;
                phase_first_cyc = cyc;
            end
        end
        if (redir) begin
            exp_pc    = rpc & ~32'h3;
            exp_fetch = exp_pc;
            epoch++;
            live = 0;
        end
        stale = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) stale++;
        check_eq("credit", 32'(int'(stale) + live <= int'(DEPTH)), 32'd1);
        last_valid = instr_valid;
        last_pop   = pop;
        cyc++;
    endtask

    initial begin
        // Latency 1, always ready: one instruction per cycle from cycle 3.
        do_reset(1, 1);
        repeat (20) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p1_first_cycle", phase_first_cyc, 32'd3);
        check_eq("p1_first_pc", phase_first_pc, 32'h0);
        check_eq("p1_pops", phase_pops, 32'd18);

        // Consumer stall with latency 2: issue stops at DEPTH.
        do_reset(2, 2);
        repeat (10) tick(1'b1, 1'b0, 1'b0, '0);
        check_eq("p2_stall_accepts", n_accept, DEPTH);
        check_eq("p2_stall_pops", phase_pops, 32'd0);
        repeat (25) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p2_release_pops", phase_pops, 32'd25);

        // Redirect with three fetches in flight.
        do_reset(4, 4);
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p3_inflight", n_accept, 32'd3);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        phase_start();
        repeat (15) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p3_first_pc", phase_first_pc, 32'h0000_0100);
        check_eq("p3_some_pops", 32'(phase_pops >= 2), 32'd1);

        // Redirect coinciding with a response and a pop.
        do_reset(1, 1);
        repeat (5) tick(1'b1, 1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check_eq("p4_pop_in_redirect", 32'(last_pop), 32'd1);
        phase_start();
        tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p4_empty_after", 32'(last_valid), 32'd0);
        repeat (8) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p4_first_pc", phase_first_pc, 32'h0000_0200);

        // Address wrap past 0xFFFF_FFFC.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4);
        phase_start();
        repeat (12) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p5_first_pc", phase_first_pc, 32'hFFFF_FFF4);
        check_eq("p5_past_wrap", 32'(phase_pops >= 5), 32'd1);

        // Back-to-back redirects.
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        phase_start();
        repeat (10) tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("p6_first_pc", phase_first_pc, 32'h0000_0080);

        // Randomized traffic: memory stalls, variable latency, consumer stalls, redirects.
        do_reset(1, 4);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 80,
                 $urandom_range(99, 0) < 3, $urandom());
        end
        check_eq("p7_progress", 32'(phase_pops >= 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
